vlane_seq: RTL and testbench

Element sequencer for one vector lane ALU. It accepts a vector instruction (length, operation class, element mask) and steps the element index through the lane ALU one element per cycle. It tracks in-flight products through the pipelined multiplier and emits ordered write-back strobes. It sits between the lane issue logic and the lane ALU/register-file write port.

---
 rtl/vlane_seq.sv | 157 +++++++++++++++
 tb/tb_vlane_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlane_seq.sv
// vlane_seq: element sequencer for one vector lane ALU.
// Latches a vector instruction at launch and steps the element index through
// the lane ALU one element per cycle. It tracks products in flight through the
// pipelined multiplier and emits write-back strobes in ascending element order.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   start_i               launch strobe, accepted only in IDLE
//   is_mul_i              launch operation class (1 = multiplier/MAC path)
//   vl_i                  launch element count, clamped to VLEN_MAX
//   mask_i                launch per-element mask
//   stall_i               write-back backpressure, freezes issue and tracking
//   req_valid_o/req_idx_o element issue strobe and operand read index
//   mask_en_o             mask bit of the issued element
//   mul_en_o              multiplier pipeline enable
//   wb_valid_o/wb_idx_o   write-back strobe and element index
//   wb_mask_o             mask bit of the written element
//   busy_o, done_o        instruction in progress, one-cycle completion pulse
module vlane_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIPE_ST    = 5,
  parameter int unsigned VLEN_MAX   = 32,
  parameter int unsigned IDX_W      = $clog2(VLEN_MAX)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                is_mul_i,
  input  logic [IDX_W:0]      vl_i,
  input  logic [VLEN_MAX-1:0] mask_i,
  input  logic                stall_i,
  output logic                req_valid_o,
  output logic [IDX_W-1:0]    req_idx_o,
  output logic                mask_en_o,
  output logic                mul_en_o,
  output logic                wb_valid_o,
  output logic [IDX_W-1:0]    wb_idx_o,
  output logic                wb_mask_o,
  output logic                busy_o,
  output logic                done_o
);

  // Tracker depth equals the product latency in enabled cycles.
  localparam int unsigned DEPTH = PIPE_ST - 1;
  localparam logic [IDX_W:0] VL_MAX = (IDX_W+1)'(VLEN_MAX);

  // Parameter sanity: the tracker needs at least one stage.
  if (PIPE_ST < 2 || DATA_WIDTH == 0) begin : g_bad_params
    $error("vlane_seq: PIPE_ST must be >= 2 and DATA_WIDTH nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W:0]        vl_q;
  logic                  is_mul_q;
  logic [VLEN_MAX-1:0]   mask_q;
  logic [DEPTH-1:0]      trk_v_q;
  logic [DEPTH-1:0]      trk_m_q;
  logic [IDX_W-1:0]      trk_idx_q [DEPTH];

  logic                  req_valid_c;
  logic                  mul_en_c;
  logic                  last_issue_c;
  logic                  trk_busy_nxt_c;
  logic [IDX_W:0]        vl_clamp_c;

  assign req_valid_c  = (state_q == S_ISSUE) && !stall_i;
  assign mul_en_c     = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && is_mul_q && !stall_i;
  assign last_issue_c = (idx_q == IDX_W'(vl_q - 1'b1));
  assign vl_clamp_c   = (vl_i > VL_MAX) ? VL_MAX : vl_i;

  // Occupancy of the tracker after this edge: a shift drops the last stage.
  always_comb begin
    trk_busy_nxt_c = mul_en_c && req_valid_c;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!mul_en_c || (k < int'(DEPTH) - 1)) begin
        trk_busy_nxt_c = trk_busy_nxt_c | trk_v_q[k];
      end
    end
  end

  // Instruction state, index counter and multiplier tracker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      vl_q     <= '0;
      is_mul_q <= 1'b0;
      mask_q   <= '0;
      trk_v_q  <= '0;
      trk_m_q  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        trk_idx_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            vl_q     <= vl_clamp_c;
            is_mul_q <= is_mul_i;
            mask_q   <= mask_i;
            idx_q    <= '0;
            state_q  <= (vl_clamp_c == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall_i) begin
            idx_q <= idx_q + 1'b1;
            if (last_issue_c) begin
              state_q <= is_mul_q ? S_DRAIN : S_DONE;
            end
          end
        end
        S_DRAIN: begin
          if (!trk_busy_nxt_c) begin
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Stage 0 takes the issued element, or a bubble when nothing issues.
      if (mul_en_c) begin
        trk_v_q[0]   <= req_valid_c;
        trk_idx_q[0] <= idx_q;
        trk_m_q[0]   <= mask_q[idx_q];
        for (int k = 1; k < int'(DEPTH); k++) begin
          trk_v_q[k]   <= trk_v_q[k-1];
          trk_idx_q[k] <= trk_idx_q[k-1];
          trk_m_q[k]   <= trk_m_q[k-1];
        end
      end
    end
  end

  assign req_valid_o = req_valid_c;
  assign req_idx_o   = idx_q;
  assign mask_en_o   = mask_q[idx_q];
  assign mul_en_o    = mul_en_c;

  // ALU results write back in the issue cycle; products leave the last stage.
  assign wb_valid_o = is_mul_q ? (trk_v_q[DEPTH-1] && !stall_i) : req_valid_c;
  assign wb_idx_o   = is_mul_q ? trk_idx_q[DEPTH-1] : idx_q;
  assign wb_mask_o  = is_mul_q ? trk_m_q[DEPTH-1] : mask_q[idx_q];

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_vlane_seq.sv
// Self-checking bench for vlane_seq: a table of directed instructions with
// expected cycle counts, hand-written reset and held-start sequences, and
// random instructions checked cycle by cycle against an effective-time model.
module tb_vlane_seq;

  localparam int unsigned PIPE_ST  = 5;
  localparam int unsigned VLEN_MAX = 32;
  localparam int unsigned IDX_W    = $clog2(VLEN_MAX);
  localparam int          D        = int'(PIPE_ST) - 1;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic                start_i = 1'b0;
  logic                is_mul_i = 1'b0;
  logic [IDX_W:0]      vl_i = '0;
  logic [VLEN_MAX-1:0] mask_i = '0;
  logic                stall_i = 1'b0;
  logic                req_valid_o;
  logic [IDX_W-1:0]    req_idx_o;
  logic                mask_en_o;
  logic                mul_en_o;
  logic                wb_valid_o;
  logic [IDX_W-1:0]    wb_idx_o;
  logic                wb_mask_o;
  logic                busy_o;
  logic                done_o;
  logic [2*IDX_W+6:0]  all_o;

  vlane_seq #(
    .DATA_WIDTH(32),
    .PIPE_ST   (PIPE_ST),
    .VLEN_MAX  (VLEN_MAX)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .is_mul_i   (is_mul_i),
    .vl_i       (vl_i),
    .mask_i     (mask_i),
    .stall_i    (stall_i),
    .req_valid_o(req_valid_o),
    .req_idx_o  (req_idx_o),
    .mask_en_o  (mask_en_o),
    .mul_en_o   (mul_en_o),
    .wb_valid_o (wb_valid_o),
    .wb_idx_o   (wb_idx_o),
    .wb_mask_o  (wb_mask_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  assign all_o = {req_valid_o, req_idx_o, mask_en_o, mul_en_o, wb_valid_o,
                  wb_idx_o, wb_mask_o, busy_o, done_o};

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic                mul;
    logic [IDX_W:0]      vl;
    logic [VLEN_MAX-1:0] mask;
    logic [255:0]        stall;
    int                  exp_done;
    int                  exp_iss;
    int                  exp_wb;
    int                  exp_wbm;
    int                  exp_first;
    int                  exp_last;
    int                  exp_mulen;
  } vec_t;

  typedef struct {
    int done_cyc;
    int iss;
    int wb;
    int wbm;
    int first;
    int last;
    int mulen;
    int ndone;
  } obs_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [255:0] sb(input int a, input int b);
    logic [255:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input bit mul, input int vl, input logic [VLEN_MAX-1:0] mask,
                              input logic [255:0] st, input int dn, input int is, input int wb,
                              input int wbm, input int fi, input int la, input int me);
    vec_t v;
    v.mul = mul; v.vl = (IDX_W+1)'(vl); v.mask = mask; v.stall = st;
    v.exp_done = dn; v.exp_iss = is; v.exp_wb = wb; v.exp_wbm = wbm;
    v.exp_first = fi; v.exp_last = la; v.exp_mulen = me;
    return v;
  endfunction

  // Runs one instruction launched at edge E0 and checks every cycle against a
  // model in "effective time": the count of non-stalled cycles since launch.
  // In effective cycle e, element e-1 issues and (ALU) writes back, or (mul)
  // element e-1-D writes back; the instruction ends after vl (ALU) or vl+D (mul)
  // effective cycles and done_o follows in the next real cycle.
  task automatic run_case(input logic mul, input logic [IDX_W:0] vl,
                          input logic [VLEN_MAX-1:0] mask, input logic [255:0] stall_pat,
                          input bit noise, input string tag, output obs_t o);
    int vlc, endf, eff, done_c, c, ei, ewi, wbe;
    bit act, stl, ereq, ewb, emul;
    vlc  = (int'(vl) > int'(VLEN_MAX)) ? int'(VLEN_MAX) : int'(vl);
    endf = (vlc == 0) ? 0 : (mul ? vlc + D : vlc);
    eff = 0;
    c   = 0;
    while (eff < endf && c < 250) begin
      c++;
      if (!stall_pat[c]) eff++;
    end
    done_c = c + 1;
    o.done_cyc = -1; o.iss = 0; o.wb = 0; o.wbm = 0;
    o.first = -1; o.last = -1; o.mulen = 0; o.ndone = 0;

    start_i = 1'b1; is_mul_i = mul; vl_i = vl; mask_i = mask; stall_i = stall_pat[0];
    @(negedge clk_i);
    chk($sformatf("%s idle before launch busy", tag), int'(busy_o), 0);
    @(posedge clk_i); #1;

    eff = 0;
    for (int cy = 1; cy <= done_c + 1; cy++) begin
      stl = stall_pat[cy];
      stall_i = stl;
      if (noise && cy <= done_c) begin
        start_i  = 1'($urandom);
        is_mul_i = 1'($urandom);
        vl_i     = (IDX_W+1)'($urandom);
        mask_i   = VLEN_MAX'($urandom);
      end else begin
        start_i = 1'b0;
      end
      act = (eff < endf);
      ereq = 1'b0; ewb = 1'b0; emul = 1'b0; ei = 0; ewi = 0;
      if (act && !stl) begin
        eff++;
        emul = mul;
        if (eff <= vlc) begin
          ereq = 1'b1;
          ei = eff - 1;
        end
        wbe = mul ? eff - D : eff;
        if (wbe >= 1 && wbe <= vlc) begin
          ewb = 1'b1;
          ewi = wbe - 1;
        end
      end
      @(negedge clk_i);
      chk($sformatf("%s c%0d req_valid", tag, cy), int'(req_valid_o), int'(ereq));
      chk($sformatf("%s c%0d wb_valid", tag, cy), int'(wb_valid_o), int'(ewb));
      chk($sformatf("%s c%0d mul_en", tag, cy), int'(mul_en_o), int'(emul));
      chk($sformatf("%s c%0d busy", tag, cy), int'(busy_o), int'(cy <= done_c));
      chk($sformatf("%s c%0d done", tag, cy), int'(done_o), int'(cy == done_c));
      if (ereq) begin
        chk($sformatf("%s c%0d req_idx", tag, cy), int'(req_idx_o), ei);
        chk($sformatf("%s c%0d mask_en", tag, cy), int'(mask_en_o), int'(mask[ei]));
      end
      if (ewb) begin
        chk($sformatf("%s c%0d wb_idx", tag, cy), int'(wb_idx_o), ewi);
        chk($sformatf("%s c%0d wb_mask", tag, cy), int'(wb_mask_o), int'(mask[ewi]));
      end
      if (req_valid_o) o.iss++;
      if (mul_en_o) o.mulen++;
      if (wb_valid_o) begin
        o.wb++;
        if (wb_mask_o) o.wbm++;
        if (o.first < 0) o.first = cy;
        o.last = cy;
      end
      if (done_o) begin
        o.ndone++;
        o.done_cyc = cy;
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic cmp_obs(input string tag, input vec_t v, input obs_t o);
    chk({tag, " done cycle"}, o.done_cyc, v.exp_done);
    chk({tag, " done pulses"}, o.ndone, 1);
    chk({tag, " issues"}, o.iss, v.exp_iss);
    chk({tag, " writebacks"}, o.wb, v.exp_wb);
    chk({tag, " unmasked writebacks"}, o.wbm, v.exp_wbm);
    chk({tag, " first wb cycle"}, o.first, v.exp_first);
    chk({tag, " last wb cycle"}, o.last, v.exp_last);
    chk({tag, " mul_en cycles"}, o.mulen, v.exp_mulen);
  endtask

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t o;
    int bad, wbs, dns;
    logic [11:0] idl;
    logic [255:0] pat;
    logic [IDX_W:0] rvl;

    tbl[0] = mk(0, 4,  32'h0000_000B, '0,         5,  4,  4,  3,  1,  4,  0);
    tbl[1] = mk(1, 3,  32'h0000_0005, '0,         8,  3,  3,  2,  5,  7,  7);
    tbl[2] = mk(1, 3,  32'h0000_0007, sb(2, 6),   10, 3,  3,  3,  7,  9,  7);
    tbl[3] = mk(0, 0,  32'hFFFF_FFFF, '0,         1,  0,  0,  0,  -1, -1, 0);
    tbl[4] = mk(1, 0,  32'hFFFF_FFFF, '0,         1,  0,  0,  0,  -1, -1, 0);
    tbl[5] = mk(0, 37, 32'hFFFF_FFFF, '0,         33, 32, 32, 32, 1,  32, 0);
    tbl[6] = mk(1, 32, 32'hF0F0_F0F0, '0,         37, 32, 32, 16, 5,  36, 36);
    tbl[7] = mk(0, 1,  32'h0000_0001, sb(1, 2),   4,  1,  1,  1,  3,  3,  0);
    tbl[8] = mk(1, 2,  32'h0000_0002, sb(3, 8),   8,  2,  2,  1,  6,  7,  6);

    // Power-on reset
    #1 rst_i = 1'b1;
    #2 chk("reset outputs", int'(all_o), 0);
    @(posedge clk_i); @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_case(tbl[i].mul, tbl[i].vl, tbl[i].mask, tbl[i].stall, 1'b0, $sformatf("vec%0d", i), o);
      cmp_obs($sformatf("vec%0d", i), tbl[i], o);
    end

    // Reset in cycle 3 of a mul vl=8 instruction
    start_i = 1'b1; is_mul_i = 1'b1; vl_i = (IDX_W+1)'(8); mask_i = '1; stall_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("midrst busy before reset", int'(busy_o), 1);
    #1 rst_i = 1'b1;
    #1 chk("midrst outputs async", int'(all_o), 0);
    @(posedge clk_i); #1;
    chk("midrst outputs held", int'(all_o), 0);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i);
      if (wb_valid_o || busy_o) bad++;
      @(posedge clk_i); #1;
    end
    chk("midrst no writeback after", bad, 0);
    run_case(tbl[1].mul, tbl[1].vl, tbl[1].mask, tbl[1].stall, 1'b0, "relaunch", o);
    cmp_obs("relaunch", tbl[1], o);

    // start_i held high, ALU vl=2: relaunch only out of IDLE
    start_i = 1'b1; is_mul_i = 1'b0; vl_i = (IDX_W+1)'(2); mask_i = '1; stall_i = 1'b0;
    wbs = 0; dns = 0; idl = '0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk_i);
      if (c >= 1) begin
        if (wb_valid_o) wbs++;
        if (done_o) dns++;
        idl[c] = !busy_o;
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    @(negedge clk_i);
    chk("held start idle after", int'(busy_o), 0);
    @(posedge clk_i); #1;
    chk("held start writebacks", wbs, 6);
    chk("held start done pulses", dns, 3);
    chk("held start idle cycles", int'(idl), 'h110);

    // Random instructions against the effective-time model
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 256; k++) pat[k] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) rvl = (IDX_W+1)'($urandom_range(0, VLEN_MAX + 4));
      else                           rvl = (IDX_W+1)'($urandom_range(0, 8));
      run_case(1'($urandom), rvl, VLEN_MAX'($urandom), pat, 1'b1, $sformatf("rnd%0d", n), o);
      chk($sformatf("rnd%0d done pulses", n), o.ndone, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
